// File: rtl/ifu_mem_responder_if.sv
// Instruction-cache refill bus between the IFU cache (master) and the
// memory-side responder (slave).
//
// Handshake: the master holds mem_reqTagValidIn/mem_reqTagIn as a level for
// as long as it wants the line; there is no ready. The responder either takes
// the request at a clock edge or silently ignores it, so a held level is
// simply presented again. Each accepted tag is answered exactly once by a
// single-cycle mem_rspInsLineValidOut pulse. The tag and line stay valid in
// that cycle and hold their values afterwards.
interface ifu_mem_responder_if #(
  parameter int TAG_WIDTH  = 28,
  parameter int LINE_WIDTH = 128
);
  logic [TAG_WIDTH-1:0]  mem_reqTagIn;
  logic                  mem_reqTagValidIn;
  logic [TAG_WIDTH-1:0]  mem_rspTagOut;
  logic [LINE_WIDTH-1:0] mem_rspInsLineOut;
  logic                  mem_rspInsLineValidOut;

  modport master (
    output mem_reqTagIn,
    output mem_reqTagValidIn,
    input  mem_rspTagOut,
    input  mem_rspInsLineOut,
    input  mem_rspInsLineValidOut
  );

  modport slave (
    input  mem_reqTagIn,
    input  mem_reqTagValidIn,
    output mem_rspTagOut,
    output mem_rspInsLineOut,
    output mem_rspInsLineValidOut
  );
endinterface

// File: rtl/ifu_mem_responder.sv
// Memory-side responder for IFU instruction-cache refills. It de-duplicates
// level-held line requests, queues them, reads a line-wide backing array a
// fixed latency after acceptance, and returns the line with its tag on a
// one-cycle valid pulse. A load port preloads the backing array.
module ifu_mem_responder #(
  parameter int TAG_WIDTH   = 28,
  parameter int LINE_WIDTH  = 128,
  parameter int MEM_DEPTH   = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         Rst,
  ifu_mem_responder_if.slave           bus,
  input  logic                         load_enIn,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_lineIdxIn,
  input  logic [LINE_WIDTH-1:0]        load_lineIn,
  output logic                         queue_fullOut,
  output logic                         busyOut,
  output logic [1:0]                   state_dbg
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]  inflight_q, inflight_d;

  logic [LINE_WIDTH-1:0] line_mem [MEM_DEPTH];

  logic [TAG_WIDTH-1:0]  fifo_tag [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        fifo_count, fifo_count_d;
  logic                  fifo_empty;

  logic [TAG_WIDTH-1:0]  shadow_tag;
  logic                  shadow_valid;

  logic                  hit_fifo, hit_inflight, hit_shadow;
  logic                  accept, push, pop, bypass, capture;

  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic [LINE_WIDTH-1:0] rsp_line;
  logic                  rsp_valid;
  logic                  queue_full, busy;

  // Distance of a storage slot from the read pointer; slots closer than the
  // count hold live entries.
  function automatic logic [PTR_W:0] slot_age(input int slot, input logic [PTR_W-1:0] rp);
    logic [PTR_W-1:0] d;
    d = PTR_W'(slot) - rp;
    return {1'b0, d};
  endfunction

  assign fifo_empty = (fifo_count == '0);

  // Duplicate detection against queued entries, the in-flight tag and the
  // tag answered in the previous cycle.
  always_comb begin
    hit_fifo = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if ((slot_age(i, rd_ptr) < fifo_count) && (fifo_tag[i] == bus.mem_reqTagIn)) begin
        hit_fifo = 1'b1;
      end
    end
    hit_inflight = (state_q != IDLE) && (inflight_q == bus.mem_reqTagIn);
    hit_shadow   = shadow_valid && (shadow_tag == bus.mem_reqTagIn);
    accept       = bus.mem_reqTagValidIn && !queue_full && !hit_fifo &&
                   !hit_inflight && !hit_shadow;
  end

  // Next-state and datapath control for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = inflight_q;
    pop        = 1'b0;
    bypass     = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          inflight_d = fifo_tag[rd_ptr];
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
        end else if (accept) begin
          bypass     = 1'b1;
          inflight_d = bus.mem_reqTagIn;
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          inflight_d = fifo_tag[rd_ptr];
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An accepted request that did not bypass into flight goes to the FIFO.
  always_comb begin
    push         = accept && !bypass;
    fifo_count_d = fifo_count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  // Sequencer registers.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // FIFO pointers and occupancy; reset flushes every queued request.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count_d;
    end
  end

  // FIFO tag storage; contents only matter where the count marks them live.
  always_ff @(posedge Clock) begin
    if (push) fifo_tag[wr_ptr] <= bus.mem_reqTagIn;
  end

  // Backing array writes; unaffected by reset so preloaded lines survive.
  always_ff @(posedge Clock) begin
    if (load_enIn) line_mem[load_lineIdxIn] <= load_lineIn;
  end

  // Response capture (reads the array before any same-edge load lands),
  // shadow tag and registered status flags.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_line     <= '0;
      queue_full   <= 1'b0;
      busy         <= 1'b0;
      shadow_valid <= 1'b0;
      shadow_tag   <= '0;
    end else begin
      rsp_valid <= capture;
      if (capture) begin
        rsp_tag  <= inflight_q;
        rsp_line <= line_mem[inflight_q[IDX_W-1:0]];
      end
      queue_full   <= (fifo_count_d == FULL_CNT);
      busy         <= (state_d != IDLE) || (fifo_count_d != '0);
      shadow_valid <= (state_q == RESP);
      if (state_q == RESP) shadow_tag <= inflight_q;
    end
  end

  assign bus.mem_rspTagOut          = rsp_tag;
  assign bus.mem_rspInsLineOut      = rsp_line;
  assign bus.mem_rspInsLineValidOut = rsp_valid;
  assign queue_fullOut              = queue_full;
  assign busyOut                    = busy;
  assign state_dbg                  = state_q;

endmodule
